// File: rtl/mux_arbiter_rv32i_pkg.sv
// Shared definitions for the two-requester round-robin arbiter.
package mux_arbiter_rv32i_pkg;

    localparam int DEFAULT_WIDTH = 32;
    localparam int COUNT_WIDTH   = 16;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

endpackage

// File: rtl/mux_arbiter_rv32i_mux2to1.sv
// Two-input data selector used on the arbiter's payload path.
module mux2to1_rv32i #(
    parameter int WIDTH = 32
) (
    input  logic             sel,
    input  logic [WIDTH-1:0] in0,
    input  logic [WIDTH-1:0] in1,
    output logic [WIDTH-1:0] y
);

    // Pass in1 when sel is high, otherwise in0.
    always_comb begin
        y = sel ? in1 : in0;
    end

endmodule

// File: rtl/mux_arbiter_rv32i.sv
// Two-requester round-robin arbiter with a single registered output word.
module mux_arbiter_rv32i
    import mux_arbiter_rv32i_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   req0_valid,
    input  logic [WIDTH-1:0]       req0_data,
    output logic                   req0_ready,
    input  logic                   req1_valid,
    input  logic [WIDTH-1:0]       req1_data,
    output logic                   req1_ready,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [WIDTH-1:0]       out_data,
    output logic                   out_src,
    output logic [COUNT_WIDTH-1:0] xfer_count
);

    state_t           state;
    state_t           next_state;
    logic             last_grant;
    logic             winner;
    logic             any_valid;
    logic             can_load;
    logic             load;
    logic             xfer;
    logic [WIDTH-1:0] sel_data;

    mux2to1_rv32i #(.WIDTH(WIDTH)) u_mux (
        .sel (winner),
        .in0 (req0_data),
        .in1 (req1_data),
        .y   (sel_data)
    );

    // Pick the winner: a lone requester wins, contention goes to the one not granted last.
    always_comb begin
        any_valid = req0_valid | req1_valid;
        if (req0_valid && req1_valid) begin
            winner = ~last_grant;
        end else begin
            winner = req1_valid;
        end
        can_load   = (state == EMPTY) | out_ready;
        load       = rst_n & can_load & any_valid;
        req0_ready = load & ~winner;
        req1_ready = load & winner;
    end

    // State register; reset drops any held word.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= EMPTY;
        end else begin
            state <= next_state;
        end
    end

    // Next state: fill on a load, drain when the word leaves with nothing to replace it.
    always_comb begin
        next_state = state;
        case (state)
            EMPTY: if (any_valid) next_state = FULL;
            FULL:  if (out_ready && !any_valid) next_state = EMPTY;
            default: next_state = EMPTY;
        endcase
    end

    // Outputs decoded from the state.
    always_comb begin
        out_valid = (state == FULL);
        xfer      = out_valid & out_ready;
    end

    // Capture the winning payload and remember who was granted.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_data   <= '0;
            out_src    <= 1'b0;
            last_grant <= 1'b1;
        end else if (load) begin
            out_data   <= sel_data;
            out_src    <= winner;
            last_grant <= winner;
        end
    end

    // Count completed output handshakes, wrapping naturally at the counter width.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            xfer_count <= '0;
        end else if (xfer) begin
            xfer_count <= xfer_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_mux_arbiter_rv32i.sv
// Directed self-checking bench for the round-robin arbiter.
module tb_mux_arbiter_rv32i;

    logic        clk;
    logic        rst_n;
    logic        req0_valid;
    logic [31:0] req0_data;
    logic        req0_ready;
    logic        req1_valid;
    logic [31:0] req1_data;
    logic        req1_ready;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        out_src;
    logic [15:0] xfer_count;

    int errors = 0;
    int checks = 0;

    mux_arbiter_rv32i #(.WIDTH(32)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req0_data  (req0_data),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_data  (req1_data),
        .req1_ready (req1_ready),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_src    (out_src),
        .xfer_count (xfer_count)
    );

    // Free-running clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic do_reset();
        rst_n      = 1'b0;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        req0_data  = '0;
        req1_data  = '0;
        out_ready  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++; $display("[TB] FAIL reset_out_valid: got %b expected 0", out_valid);
        end
        checks++;
        if (xfer_count !== 16'h0000) begin
            errors++; $display("[TB] FAIL reset_count: got %h expected 0000", xfer_count);
        end
        checks++;
        if ({req0_ready, req1_ready} !== 2'b00) begin
            errors++; $display("[TB] FAIL reset_readies: got %b expected 00", {req0_ready, req1_ready});
        end
        rst_n      = 1'b0;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        #1;
        checks++;
        if ({req0_ready, req1_ready} !== 2'b00) begin
            errors++; $display("[TB] FAIL ready_in_reset: got %b expected 00", {req0_ready, req1_ready});
        end
        @(posedge clk); #1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        rst_n      = 1'b1;
    endtask

    task automatic test_single();
        do_reset();
        req0_valid = 1'b1;
        req0_data  = 32'hAAAAAAAA;
        #1;
        checks++;
        if ({req0_ready, req1_ready} !== 2'b10) begin
            errors++; $display("[TB] FAIL single_ready: got %b expected 10", {req0_ready, req1_ready});
        end
        @(posedge clk); #1;
        req0_valid = 1'b0;
        checks++;
        if ({out_valid, out_src, out_data} !== {1'b1, 1'b0, 32'hAAAAAAAA}) begin
            errors++; $display("[TB] FAIL single_out: got v=%b s=%b d=%h expected v=1 s=0 d=aaaaaaaa", out_valid, out_src, out_data);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        checks++;
        if ({out_valid, xfer_count} !== {1'b0, 16'd1}) begin
            errors++; $display("[TB] FAIL single_drain: got v=%b cnt=%0d expected v=0 cnt=1", out_valid, xfer_count);
        end
    endtask

    task automatic test_round_robin();
        logic [31:0] exp_data;
        do_reset();
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        req0_data  = 32'h12345678;
        req1_data  = 32'hABCDEF01;
        out_ready  = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++;
            if ({req0_ready, req1_ready} !== ((i % 2 == 0) ? 2'b10 : 2'b01)) begin
                errors++; $display("[TB] FAIL rr_ready_%0d: got %b", i, {req0_ready, req1_ready});
            end
            @(posedge clk); #1;
            exp_data = (i % 2 == 0) ? 32'h12345678 : 32'hABCDEF01;
            checks++;
            if ({out_valid, out_src, out_data} !== {1'b1, 1'(i % 2), exp_data}) begin
                errors++; $display("[TB] FAIL rr_out_%0d: got v=%b s=%b d=%h expected s=%0d d=%h", i, out_valid, out_src, out_data, i % 2, exp_data);
            end
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        @(posedge clk); #1;
        out_ready = 1'b0;
        checks++;
        if ({out_valid, xfer_count} !== {1'b0, 16'd4}) begin
            errors++; $display("[TB] FAIL rr_count: got v=%b cnt=%0d expected v=0 cnt=4", out_valid, xfer_count);
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        req0_valid = 1'b1;
        req0_data  = 32'h87654321;
        @(posedge clk); #1;
        req0_valid = 1'b0;
        req1_valid = 1'b1;
        req1_data  = 32'h0BADF00D;
        for (int i = 0; i < 5; i++) begin
            #1;
            checks++;
            if ({out_valid, out_data, req1_ready} !== {1'b1, 32'h87654321, 1'b0}) begin
                errors++; $display("[TB] FAIL bp_hold_%0d: got v=%b d=%h r1=%b expected v=1 d=87654321 r1=0", i, out_valid, out_data, req1_ready);
            end
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        #1;
        checks++;
        if (req1_ready !== 1'b1) begin
            errors++; $display("[TB] FAIL bp_release_ready: got %b expected 1", req1_ready);
        end
        @(posedge clk); #1;
        req1_valid = 1'b0;
        checks++;
        if ({out_valid, out_src, out_data, xfer_count} !== {1'b1, 1'b1, 32'h0BADF00D, 16'd1}) begin
            errors++; $display("[TB] FAIL bp_next: got v=%b s=%b d=%h cnt=%0d expected v=1 s=1 d=0badf00d cnt=1", out_valid, out_src, out_data, xfer_count);
        end
        @(posedge clk); #1;
        out_ready = 1'b0;
        checks++;
        if ({out_valid, xfer_count} !== {1'b0, 16'd2}) begin
            errors++; $display("[TB] FAIL bp_drain: got v=%b cnt=%0d expected v=0 cnt=2", out_valid, xfer_count);
        end
    endtask

    task automatic test_ready_when_empty();
        do_reset();
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        out_ready = 1'b0;
        checks++;
        if ({out_valid, xfer_count} !== {1'b0, 16'd0}) begin
            errors++; $display("[TB] FAIL empty_ready: got v=%b cnt=%0d expected v=0 cnt=0", out_valid, xfer_count);
        end
    endtask

    task automatic test_mid_reset();
        do_reset();
        req0_valid = 1'b1;
        req0_data  = 32'h11112222;
        @(posedge clk); #1;
        rst_n     = 1'b0;
        out_ready = 1'b1;
        #1;
        checks++;
        if ({req0_ready, req1_ready} !== 2'b00) begin
            errors++; $display("[TB] FAIL midrst_ready: got %b expected 00", {req0_ready, req1_ready});
        end
        @(posedge clk); #1;
        checks++;
        if ({out_valid, xfer_count, out_data} !== {1'b0, 16'd0, 32'h0}) begin
            errors++; $display("[TB] FAIL midrst_state: got v=%b cnt=%0d d=%h expected v=0 cnt=0 d=0", out_valid, xfer_count, out_data);
        end
        rst_n      = 1'b1;
        out_ready  = 1'b0;
        req1_valid = 1'b1;
        req1_data  = 32'h33334444;
        #1;
        checks++;
        if ({req0_ready, req1_ready} !== 2'b10) begin
            errors++; $display("[TB] FAIL midrst_contend: got %b expected 10", {req0_ready, req1_ready});
        end
        @(posedge clk); #1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        checks++;
        if ({out_src, out_data} !== {1'b0, 32'h11112222}) begin
            errors++; $display("[TB] FAIL midrst_winner: got s=%b d=%h expected s=0 d=11112222", out_src, out_data);
        end
    endtask

    task automatic test_wrap();
        do_reset();
        req0_valid = 1'b1;
        req0_data  = 32'h55555555;
        out_ready  = 1'b1;
        repeat (65536) @(posedge clk);
        #1;
        checks++;
        if ({out_valid, xfer_count} !== {1'b1, 16'hFFFF}) begin
            errors++; $display("[TB] FAIL wrap_top: got v=%b cnt=%h expected v=1 cnt=ffff", out_valid, xfer_count);
        end
        @(posedge clk); #1;
        checks++;
        if (xfer_count !== 16'h0000) begin
            errors++; $display("[TB] FAIL wrap_zero: got %h expected 0000", xfer_count);
        end
        req0_valid = 1'b0;
        out_ready  = 1'b0;
    endtask

    // Run every scenario in order, then report.
    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_backpressure();
        test_ready_when_empty();
        test_mid_reset();
        test_wrap();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
